spi_slave_rx: RTL and testbench

- Downstream receive stage for the team's 16-bit SPI master. Consumes its chip-select, serial clock and serial data outputs.
- Synchronises the three lines into the local clk domain and detects serial-clock rising edges.
- Deserialises MSB-first words and buffers them in a small FIFO, presented to the fabric over a valid/ready interface.
- Reports overrun (FIFO full) and framing errors (chip-select released mid-word).

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_rx_fifo.sv | 62 ++++++
 rtl/spi_slave_rx.sv | 117 +++++++++++
 tb/tb_spi_slave_rx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants used by the 16-bit master and by the receive stage.
package spi_pkg;

  // Word length carried by one chip-select slot.
  localparam int SPI_WORD_W = 16;

  // Levels the master drives when no transfer is in progress.
  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;

  // Bit order on the wire: 1 = most significant bit first.
  localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_rx_fifo.sv
// Small circular receive buffer with read-through head and occupancy count.
module spi_rx_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        full,
  output logic                        empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;
  logic              do_wr;
  logic              do_rd;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == LVL_W'(FIFO_DEPTH));
  // A read on an empty buffer is ignored; a write into a full buffer only
  // lands when a read frees the head slot in the same cycle.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign level   = level_reg;
  // Head word is shown only while something is held, so it reads 0 when empty.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  // Storage array; no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive stage: synchronises cs/sclk/data, deserialises words on sclk
// rising edges and queues them for the fabric over valid/ready.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_WORD_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        spi_cs_l,
  input  logic                        spi_clk,
  input  logic                        spi_data,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        overrun,
  output logic                        frame_err,
  input  logic                        clear_err
);

  localparam int CNT_W = $clog2(DATA_W);
  // Bundle order {cs, sclk, data}; reset to the idle line levels.
  localparam logic [2:0] SYNC_RST = {CS_IDLE, SCLK_IDLE, 1'b0};

  logic [2:0]        sync_reg [SYNC_STAGES];
  logic              cs_s, clk_s, data_s;
  logic              clk_prev_reg, cs_prev_reg;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              overrun_reg, frame_err_reg;
  logic              rise, sample, word_done, frame_abort, word_drop;
  logic              fifo_full, fifo_empty;

  // All three lines share one chain so their relative timing is preserved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= SYNC_RST;
    end else begin
      sync_reg[0] <= {spi_cs_l, spi_clk, spi_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign cs_s   = sync_reg[SYNC_STAGES-1][2];
  assign clk_s  = sync_reg[SYNC_STAGES-1][1];
  assign data_s = sync_reg[SYNC_STAGES-1][0];

  // Previous synced sclk and cs, for rising-edge and cs-release detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_prev_reg <= SCLK_IDLE;
      cs_prev_reg  <= CS_IDLE;
    end else begin
      clk_prev_reg <= clk_s;
      cs_prev_reg  <= cs_s;
    end
  end

  assign rise        = clk_s & ~clk_prev_reg;
  assign sample      = rise & ~cs_s;
  assign word_done   = sample & (bit_cnt_reg == CNT_W'(DATA_W - 1));
  assign frame_abort = cs_s & ~cs_prev_reg & (bit_cnt_reg != '0);
  assign shift_next  = MSB_FIRST ? {shift_reg[DATA_W-2:0], data_s}
                                 : {data_s, shift_reg[DATA_W-1:1]};
  // A full buffer frees a slot only when the consumer pops in the same cycle.
  assign word_drop   = word_done & fifo_full & ~rx_ready;

  // Shifter and bit counter; an aborted frame throws away the partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (frame_abort) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (sample) begin
      shift_reg   <= shift_next;
      bit_cnt_reg <= word_done ? '0 : bit_cnt_reg + CNT_W'(1);
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      overrun_reg   <= word_drop   | (overrun_reg   & ~clear_err);
      frame_err_reg <= frame_abort | (frame_err_reg & ~clear_err);
    end
  end

  spi_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (word_done),
    .wr_data (shift_next),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rx_valid  = ~fifo_empty;
  assign busy      = ~cs_s | (bit_cnt_reg != '0);
  assign overrun   = overrun_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx with a word-level reference model.
module tb_spi_slave_rx;

  localparam int SYNC  = 2;
  localparam int DEPTH = 4;
  // Pin change -> synced after SYNC edges -> word stored one edge later.
  localparam int LAT   = SYNC + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs_l, spi_clk, spi_data;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
  logic [2:0]  fifo_level;
  logic        busy, overrun, frame_err, clear_err;

  spi_slave_rx #(.DATA_W(16), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .spi_cs_l(spi_cs_l), .spi_clk(spi_clk),
    .spi_data(spi_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .fifo_level(fifo_level), .busy(busy),
    .overrun(overrun), .frame_err(frame_err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  typedef struct { int due; bit abort; logic [15:0] data; } ev_t;

  // Events issued by the driver (written only by the stimulus process).
  ev_t         pend[$];
  int          pin_bits = 0;
  logic [15:0] pin_word = '0;
  int          last_hi_cyc = 0;

  // Reference model state (written only by the model process).
  int          cyc = 0;
  int          ev_idx = 0;
  logic [15:0] mq[$];
  logic [15:0] dut_popped[$];
  bit          m_ovr = 0, m_ferr = 0;

  // Samples of DUT outputs taken at the falling edge.
  logic        s_valid = 0;
  logic [15:0] s_data = '0;

  int total = 0, bad = 0;

  // Word-level model: each clock applies pop, then any word/abort that the
  // driver issued LAT edges earlier.
  bit          m_pop, m_wr, m_ab, m_drop;
  logic [15:0] m_wd;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      mq.delete();
      m_ovr  = 0;
      m_ferr = 0;
      ev_idx = pend.size();
    end else begin
      m_pop = (mq.size() != 0) && rx_ready;
      if (s_valid && rx_ready) dut_popped.push_back(s_data);
      m_wr = 0; m_ab = 0; m_wd = '0;
      while (ev_idx < pend.size() && pend[ev_idx].due <= cyc) begin
        if (pend[ev_idx].abort) m_ab = 1;
        else begin m_wr = 1; m_wd = pend[ev_idx].data; end
        ev_idx++;
      end
      m_drop = m_wr && (mq.size() == DEPTH) && !m_pop;
      if (m_pop) void'(mq.pop_front());
      if (m_wr && !m_drop) mq.push_back(m_wd);
      m_ovr  = (m_ovr  && !clear_err) || m_drop;
      m_ferr = (m_ferr && !clear_err) || m_ab;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    chk("rx_valid", rx_valid, (mq.size() != 0));
    chk("fifo_level", fifo_level, mq.size());
    if (mq.size() != 0) chk("rx_data", rx_data, mq[0]);
    chk("overrun", overrun, m_ovr);
    chk("frame_err", frame_err, m_ferr);
  endtask

  // One clock: check at the falling edge, then let stimulus change 1ns later.
  task automatic step();
    @(negedge clk);
    if (!reset) compare_all();
    s_valid = rx_valid;
    s_data  = rx_data;
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic cs_low();
    step();
    spi_cs_l = 1'b0;
  endtask

  task automatic cs_high();
    step();
    spi_cs_l = 1'b1;
    if (pin_bits != 0) pend.push_back('{due: cyc + LAT, abort: 1'b1, data: '0});
    pin_bits = 0;
  endtask

  // Sends the top n bits of w MSB-first, one clk low then one clk high each.
  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      spi_clk  = 1'b0;
      spi_data = w[15-i];
      step();
      spi_clk  = 1'b1;
      last_hi_cyc = cyc;
      pin_word = {pin_word[14:0], w[15-i]};
      pin_bits++;
      if (pin_bits == 16) begin
        pend.push_back('{due: cyc + LAT, abort: 1'b0, data: pin_word});
        pin_bits = 0;
      end
    end
    step();
    spi_clk = 1'b0;
  endtask

  task automatic drain(input int n);
    rx_ready = 1'b1;
    settle(n);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    step();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
  endtask

  function automatic logic [15:0] pget(input int i);
    if (i < dut_popped.size()) return dut_popped[i];
    return 16'hDEAD;
  endfunction

  int base;

  initial begin
    reset = 1'b1; spi_cs_l = 1'b1; spi_clk = 1'b0; spi_data = 1'b0;
    rx_ready = 1'b0; clear_err = 1'b0;
    settle(3);
    chk("rst rx_valid", rx_valid, 0);
    chk("rst rx_data", rx_data, 0);
    chk("rst level", fifo_level, 0);
    chk("rst busy", busy, 0);
    chk("rst overrun", overrun, 0);
    chk("rst frame_err", frame_err, 0);
    step(); reset = 1'b0;
    settle(3);

    // Single word consumed immediately.
    base = dut_popped.size();
    rx_ready = 1'b1;
    cs_low(); send_bits(16'hA5C3, 16); cs_high();
    settle(LAT + 3);
    rx_ready = 1'b0;
    chk("single count", dut_popped.size() - base, 1);
    chk("single word", pget(base), 16'hA5C3);
    chk("single frame_err", frame_err, 0);
    chk("single level", fifo_level, 0);
    chk("single busy", busy, 0);

    // Two words back-to-back in one frame, held until drained.
    base = dut_popped.size();
    cs_low(); send_bits(16'h1234, 16); send_bits(16'hFFFF, 16); cs_high();
    settle(LAT + 2);
    chk("b2b level", fifo_level, 2);
    drain(4);
    chk("b2b word0", pget(base), 16'h1234);
    chk("b2b word1", pget(base + 1), 16'hFFFF);

    // Five words into a four-entry buffer.
    base = dut_popped.size();
    cs_low();
    for (int w = 1; w <= 5; w++) send_bits(16'(w), 16);
    cs_high();
    settle(LAT + 2);
    chk("ovr level", fifo_level, 4);
    chk("ovr flag", overrun, 1);
    drain(6);
    for (int w = 0; w < 4; w++) chk("ovr pop", pget(base + w), 16'(w + 1));
    chk("ovr popped n", dut_popped.size() - base, 4);
    pulse_clear();
    settle(2);
    chk("ovr cleared", overrun, 0);

    // Full buffer with a pop in the very cycle the fifth word lands.
    base = dut_popped.size();
    cs_low();
    for (int w = 0; w < 4; w++) send_bits(16'h0011 + 16'(w), 16);
    send_bits(16'h0015, 16);
    while (cyc < last_hi_cyc + LAT - 1) step();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    cs_high();
    settle(LAT + 2);
    chk("fullpop level", fifo_level, 4);
    chk("fullpop overrun", overrun, 0);
    chk("fullpop first", pget(base), 16'h0011);
    drain(6);
    for (int w = 1; w < 5; w++) chk("fullpop drain", pget(base + w), 16'h0011 + 16'(w));

    // Chip select released after seven bits, then a good word.
    base = dut_popped.size();
    cs_low(); send_bits(16'hFE00, 7);
    settle(LAT);
    chk("abort busy mid", busy, 1);
    cs_high();
    settle(LAT + 2);
    chk("abort frame_err", frame_err, 1);
    chk("abort level", fifo_level, 0);
    chk("abort busy end", busy, 0);
    cs_low(); send_bits(16'h00FF, 16); cs_high();
    settle(LAT + 2);
    drain(3);
    chk("after abort word", pget(base), 16'h00FF);
    chk("after abort n", dut_popped.size() - base, 1);
    pulse_clear();
    settle(2);
    chk("ferr cleared", frame_err, 0);

    // Reset in the middle of a word with two words buffered.
    cs_low(); send_bits(16'h1111, 16); send_bits(16'h2222, 16);
    send_bits(16'h3333, 9);
    chk("pre-reset level", fifo_level, 2);
    step();
    reset = 1'b1;
    #1;
    chk("mid rst rx_valid", rx_valid, 0);
    chk("mid rst rx_data", rx_data, 0);
    chk("mid rst level", fifo_level, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst overrun", overrun, 0);
    chk("mid rst frame_err", frame_err, 0);
    spi_cs_l = 1'b1; spi_clk = 1'b0; pin_bits = 0;
    settle(3);
    reset = 1'b0;
    settle(3);
    base = dut_popped.size();
    cs_low(); send_bits(16'hBEEF, 16); cs_high();
    settle(LAT + 2);
    chk("post rst level", fifo_level, 1);
    drain(3);
    chk("post rst word", pget(base), 16'hBEEF);
    chk("post rst frame_err", frame_err, 0);
    settle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
